contador_hacia_arriba_en_ud: RTL and testbench



---
 rtl/contador_hacia_arriba_en_ud_if.sv | 24 ++
 rtl/contador_hacia_arriba_en_ud.sv | 39 +++
 tb/tb_contador_hacia_arriba_en_ud.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/contador_hacia_arriba_en_ud_if.sv
// rtl/contador_hacia_arriba_en_ud_if.sv - control and count bundle for the up/down counter
interface contador_hacia_arriba_en_ud_if #(
  parameter int WIDTH = 4
);

  logic             enable;
  logic             UD;
  logic [WIDTH-1:0] cuenta;

  // Side that drives the count controls and observes the count.
  modport master (
    output enable,
    output UD,
    input  cuenta
  );

  // The counter itself.
  modport slave (
    input  enable,
    input  UD,
    output cuenta
  );

endinterface

// File: rtl/contador_hacia_arriba_en_ud.sv
// rtl/contador_hacia_arriba_en_ud.sv - modulo 2^WIDTH up/down counter with count enable
module contador_hacia_arriba_en_ud #(
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  contador_hacia_arriba_en_ud_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cuenta_q;
  logic [WIDTH-1:0] cuenta_d;

  // Next count: hold when disabled, otherwise one step in the selected direction.
  // Natural overflow of the WIDTH-bit sum gives the 15->0 and 0->15 wrap.
  always_comb begin
    cuenta_d = cuenta_q;
    if (bus.enable) begin
      if (bus.UD) begin
        cuenta_d = cuenta_q + ONE;
      end else begin
        cuenta_d = cuenta_q - ONE;
      end
    end
  end

  // Count register; reset clears it immediately, independent of the clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  assign bus.cuenta = cuenta_q;

endmodule

// File: tb/tb_contador_hacia_arriba_en_ud.sv
// tb/tb_contador_hacia_arriba_en_ud.sv - self-checking bench for the up/down counter
module tb_contador_hacia_arriba_en_ud;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  contador_hacia_arriba_en_ud_if #(.WIDTH(W)) bus ();

  contador_hacia_arriba_en_ud #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int model       = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input int exp);
    logic [W-1:0] e;
    e = W'(exp);
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL %s: cuenta=%0d expected=%0d at t=%0t", tag, got, e, $time);
    end
  endtask

  // Drive controls now, take one rising edge, advance the model, check.
  task automatic edge_and_check(input string tag, input logic en, input logic ud);
    bus.enable = en;
    bus.UD     = ud;
    @(posedge clk);
    if (en) begin
      if (ud) model = (model + 1) % MOD;
      else    model = (model + MOD - 1) % MOD;
    end
    #1;
    check(tag, bus.cuenta, model);
  endtask

  task automatic step(input string tag, input logic en, input logic ud);
    @(negedge clk);
    edge_and_check(tag, en, ud);
  endtask

  // Pulse reset between edges and confirm the clear happens before any clock.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #($urandom_range(1, 2));
    bus.enable = 1'b0;
    rst = 1'b0;
    #1;
    model = 0;
    check(tag, bus.cuenta, 0);
    #1;
    rst = 1'b1;
  endtask

  task automatic go_to(input int v);
    async_reset("goto_rst");
    for (int i = 0; i < v; i++) step("goto_up", 1'b1, 1'b1);
  endtask

  initial begin
    rst        = 1'b0;
    bus.enable = 1'b1;
    bus.UD     = 1'b1;
    #1;
    check("reset_initial", bus.cuenta, 0);

    // Reset held with enable/UD active: count must stay 0.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_held", bus.cuenta, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    model = 0;
    edge_and_check("reset_release_first", 1'b1, 1'b1);

    // Count up 10 from 0, then wrap after 16 total.
    async_reset("up_rst");
    for (int i = 0; i < 10; i++) step("count_up", 1'b1, 1'b1);
    check("count_up_10", bus.cuenta, 10);
    for (int i = 0; i < 6; i++) step("count_up_wrap", 1'b1, 1'b1);
    check("wrap_15_to_0", bus.cuenta, 0);

    // Count down from 10 and from 0.
    go_to(10);
    step("down_from_10", 1'b1, 1'b0);
    check("down_10_to_9", bus.cuenta, 9);
    async_reset("down_rst");
    step("down_from_0", 1'b1, 1'b0);
    check("wrap_0_to_15", bus.cuenta, 15);

    // Enable hold with UD toggling.
    go_to(5);
    for (int i = 0; i < 4; i++) step("hold", 1'b0, 1'(i % 2));
    check("hold_5", bus.cuenta, 5);
    step("reenable", 1'b1, 1'b1);
    check("reenable_6", bus.cuenta, 6);

    // Async reset mid-operation at 7, then resume from 0.
    go_to(7);
    check("at_7", bus.cuenta, 7);
    async_reset("midcount_rst");
    step("resume", 1'b1, 1'b1);
    check("resume_1", bus.cuenta, 1);

    // Direction flip every cycle from 3.
    go_to(3);
    step("flip_up", 1'b1, 1'b1);
    check("flip_4", bus.cuenta, 4);
    step("flip_dn", 1'b1, 1'b0);
    check("flip_3", bus.cuenta, 3);
    step("flip_up", 1'b1, 1'b1);
    check("flip_4b", bus.cuenta, 4);
    step("flip_dn", 1'b1, 1'b0);
    check("flip_3b", bus.cuenta, 3);

    // Randomized traffic with occasional async resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        async_reset("rand_rst");
      end else begin
        step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
